// File: rtl/mem_arb_if.sv
// mem_arb_if: bundles the IFU, LSU and memory-side signals of mem_arb.
//
// Signal groups:
//   IFU    : ifu_req, ifu_addr -> ifu_gnt, ifu_rvalid, ifu_rdata
//   LSU    : lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask
//            -> lsu_gnt, lsu_rvalid, lsu_rdata
//   Memory : mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
//            <- mem_gnt, mem_rvalid, mem_rdata
//
// Modports:
//   slave  : the arbiter's view (masters' requests and memory responses in).
//   master : the environment's view (masters and memory model).
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IFU side
  logic                ifu_req;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_gnt;
  logic                ifu_rvalid;
  logic [DATA_W-1:0]   ifu_rdata;
  // LSU side
  logic                lsu_req;
  logic                lsu_we;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_gnt;
  logic                lsu_rvalid;
  logic [DATA_W-1:0]   lsu_rdata;
  // Memory side
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ifu_gnt, ifu_rvalid, ifu_rdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ifu_gnt, ifu_rvalid, ifu_rdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: shares a single memory port between instruction fetch (IFU) and
// load/store (LSU). One transaction outstanding at a time; the request to
// memory is registered, the response is passed straight back to the owner.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : mem_arb_if.slave carrying the IFU, LSU and memory signals
//
// Configuration macro:
//   MEM_ARB_RR_EN : when defined, ties are broken round-robin using a 1-bit
//                   last-served pointer; otherwise LSU always wins ties.
//
// Flow: IDLE (grant, capture fields) -> REQ (mem_req until mem_gnt)
//       -> WAIT (until mem_rvalid, forwarded to owner) -> IDLE.
module mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  state_e              state_q;
  owner_e              owner_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W/8-1:0] mem_wmask_q;

  logic any_req;
  logic pick_lsu;
  logic arb_idle;
  logic resp;
  logic ifu_rvalid_w;
  logic lsu_rvalid_w;

  assign any_req  = bus.ifu_req | bus.lsu_req;
  assign arb_idle = (state_q == S_IDLE) & ~rst;

`ifdef MEM_ARB_RR_EN
  // 1 = LSU was served last. Reset value makes IFU win the first tie.
  logic last_lsu_q;

  assign pick_lsu = bus.lsu_req & (~bus.ifu_req | ~last_lsu_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu_q <= 1'b1;
    end else if (state_q == S_IDLE && any_req) begin
      last_lsu_q <= pick_lsu;
    end
  end
`else
  // Fixed priority: LSU wins whenever it asks.
  assign pick_lsu = bus.lsu_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IFU;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q   <= S_REQ;
            mem_req_q <= 1'b1;
            if (pick_lsu) begin
              owner_q     <= OWN_LSU;
              mem_we_q    <= bus.lsu_we;
              mem_addr_q  <= bus.lsu_addr;
              mem_wdata_q <= bus.lsu_wdata;
              mem_wmask_q <= bus.lsu_wmask;
            end else begin
              // Fetches are always plain reads.
              owner_q     <= OWN_IFU;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.ifu_addr;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
            end
          end
        end
        S_REQ: begin
          // A response seen here is stray and deliberately ignored.
          if (bus.mem_gnt) begin
            state_q   <= S_WAIT;
            mem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Grants are decided combinationally in IDLE so the master sees them in
  // the same cycle its request is captured.
  assign bus.ifu_gnt = arb_idle & bus.ifu_req & ~pick_lsu;
  assign bus.lsu_gnt = arb_idle & pick_lsu;

  // Only a response in WAIT belongs to the owner; anything else is dropped.
  assign resp         = (state_q == S_WAIT) & bus.mem_rvalid & ~rst;
  assign ifu_rvalid_w = resp & (owner_q == OWN_IFU);
  assign lsu_rvalid_w = resp & (owner_q == OWN_LSU);

  assign bus.ifu_rvalid = ifu_rvalid_w;
  assign bus.lsu_rvalid = lsu_rvalid_w;
  assign bus.ifu_rdata  = ifu_rvalid_w ? bus.mem_rdata : '0;
  // A write acknowledge carries no data.
  assign bus.lsu_rdata  = (lsu_rvalid_w && !mem_we_q) ? bus.mem_rdata : '0;

  // Memory request fields come from registers; they are also held at zero
  // while reset is asserted so every output reads 0 during reset.
  assign bus.mem_req   = mem_req_q & ~rst;
  assign bus.mem_we    = mem_we_q & ~rst;
  assign bus.mem_addr  = rst ? '0 : mem_addr_q;
  assign bus.mem_wdata = rst ? '0 : mem_wdata_q;
  assign bus.mem_wmask = rst ? '0 : mem_wmask_q;

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic lsu, input logic [31:0] data);
    exp_t e;
    e.lsu  = lsu;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Completes a transaction granted in the current cycle: mem_gnt at c+1,
  // response at c+2, returns at the start of c+3 (IDLE again).
  task automatic finish_txn(input logic lsu, input logic [31:0] addr,
                            input logic [31:0] rd, input logic wr, input logic hold);
    tick();
    if (!hold) begin
      bus.ifu_req = 1'b0;
      bus.lsu_req = 1'b0;
    end
    bus.mem_gnt = 1'b1;
    mid();
    check("txn_mem_req", 64'(bus.mem_req), 64'(1));
    check("txn_mem_addr", 64'(bus.mem_addr), 64'(addr));
    check("txn_mem_we", 64'(bus.mem_we), 64'(wr));
    check("txn_busy_gnt", 64'({bus.ifu_gnt, bus.lsu_gnt}), 64'(0));
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    push_exp(lsu, wr ? 32'h0 : rd);
    mid();
    check("txn_req_drop", 64'(bus.mem_req), 64'(0));
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  // Response monitor: every master rvalid must match the scoreboard head,
  // and every expected response must appear in the cycle it was driven.
  always @(negedge clk) begin
    if (bus.ifu_rvalid || bus.lsu_rvalid) begin
      if (sb_q.size() == 0) begin
        check("rv_unexpected", 64'({bus.ifu_rvalid, bus.lsu_rvalid}), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("rv_owner", 64'({bus.ifu_rvalid, bus.lsu_rvalid}),
              64'(mon_e.lsu ? 2'b01 : 2'b10));
        check("rv_data", 64'(mon_e.lsu ? bus.lsu_rdata : bus.ifu_rdata), 64'(mon_e.data));
        $display("txn: owner=%s rdata=%08h", mon_e.lsu ? "LSU" : "IFU",
                 mon_e.lsu ? bus.lsu_rdata : bus.ifu_rdata);
      end
    end else if (sb_q.size() != 0) begin
      check("rv_missing", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
    end
    if (!bus.ifu_rvalid && bus.ifu_rdata != 32'h0)
      check("ifu_rdata_idle", 64'(bus.ifu_rdata), 64'(0));
    if (!bus.lsu_rvalid && bus.lsu_rdata != 32'h0)
      check("lsu_rdata_idle", 64'(bus.lsu_rdata), 64'(0));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic exp_lsu;

  initial begin
    rst            = 1'b1;
    bus.ifu_req    = 1'b0;
    bus.ifu_addr   = '0;
    bus.lsu_req    = 1'b0;
    bus.lsu_we     = 1'b0;
    bus.lsu_addr   = '0;
    bus.lsu_wdata  = '0;
    bus.lsu_wmask  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    tick();
    mid();
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_gnts", 64'({bus.ifu_gnt, bus.lsu_gnt}), 64'(0));
    tick();
    rst = 1'b0;

    // 1: IFU-only read
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h8000_0000;
    mid();
    check("t1_ifu_gnt", 64'(bus.ifu_gnt), 64'(1));
    check("t1_lsu_gnt", 64'(bus.lsu_gnt), 64'(0));
    check("t1_mem_req_c0", 64'(bus.mem_req), 64'(0));
    tick();
    bus.ifu_req  = 1'b0;
    bus.ifu_addr = 32'h0;
    bus.mem_gnt  = 1'b1;
    mid();
    check("t1_mem_req", 64'(bus.mem_req), 64'(1));
    check("t1_mem_we", 64'(bus.mem_we), 64'(0));
    check("t1_mem_addr", 64'(bus.mem_addr), 64'(32'h8000_0000));
    check("t1_mem_wmask", 64'(bus.mem_wmask), 64'(0));
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0010_0073;
    push_exp(1'b0, 32'h0010_0073);
    mid();
    check("t1_ifu_rvalid", 64'(bus.ifu_rvalid), 64'(1));
    check("t1_ifu_rdata", 64'(bus.ifu_rdata), 64'(32'h0010_0073));
    check("t1_lsu_rvalid", 64'(bus.lsu_rvalid), 64'(0));
    tick();
    bus.mem_rvalid = 1'b0;

    // 2: LSU write with mem_gnt delayed 3 cycles
    bus.lsu_req   = 1'b1;
    bus.lsu_we    = 1'b1;
    bus.lsu_addr  = 32'h8000_1000;
    bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_wmask = 4'h3;
    mid();
    check("t2_lsu_gnt", 64'(bus.lsu_gnt), 64'(1));
    check("t2_ifu_gnt", 64'(bus.ifu_gnt), 64'(0));
    tick();
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = 32'hFFFF_FFFF;
    bus.lsu_wdata = 32'h0;
    bus.lsu_wmask = 4'h0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_gnt = (k == 3);
      mid();
      check($sformatf("t2_req_%0d", k), 64'(bus.mem_req), 64'(1));
      check($sformatf("t2_fields_%0d", k),
            {bus.mem_we, bus.mem_wmask, bus.mem_addr[26:0], bus.mem_wdata},
            {1'b1, 4'h3, 27'h000_1000, 32'hDEAD_BEEF});
      tick();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    push_exp(1'b1, 32'h0);
    mid();
    check("t2_req_drop", 64'(bus.mem_req), 64'(0));
    check("t2_lsu_rvalid", 64'(bus.lsu_rvalid), 64'(1));
    check("t2_lsu_rdata", 64'(bus.lsu_rdata), 64'(0));
    tick();
    bus.mem_rvalid = 1'b0;

    // 3: simultaneous held requests, starting from reset
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.ifu_req   = 1'b1;
    bus.ifu_addr  = 32'h8000_0100;
    bus.lsu_req   = 1'b1;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = 32'h8000_2000;
    bus.lsu_wdata = 32'h1111_1111;
    bus.lsu_wmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_lsu = (i % 2) == 1;
`else
      exp_lsu = 1'b1;
`endif
      mid();
      check($sformatf("t3_gnt_%0d", i), 64'({bus.ifu_gnt, bus.lsu_gnt}),
            64'(exp_lsu ? 2'b01 : 2'b10));
      finish_txn(exp_lsu, exp_lsu ? 32'h8000_2000 : 32'h8000_0100,
                 32'hA000_0000 | 32'(i), 1'b0, 1'b1);
    end
    bus.ifu_req = 1'b0;
    bus.lsu_req = 1'b0;
    tick();

    // 4: LSU request arriving while IFU transaction is in WAIT
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h8000_0200;
    mid();
    check("t4_ifu_gnt", 64'(bus.ifu_gnt), 64'(1));
    tick();
    bus.ifu_req = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt  = 1'b0;
    bus.lsu_req  = 1'b1;
    bus.lsu_we   = 1'b0;
    bus.lsu_addr = 32'h8000_3000;
    mid();
    check("t4_wait_gnt_a", 64'(bus.lsu_gnt), 64'(0));
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0BAD_F00D;
    push_exp(1'b0, 32'h0BAD_F00D);
    mid();
    check("t4_wait_gnt_b", 64'(bus.lsu_gnt), 64'(0));
    tick();
    bus.mem_rvalid = 1'b0;
    mid();
    check("t4_idle_gnt", 64'(bus.lsu_gnt), 64'(1));
    finish_txn(1'b1, 32'h8000_3000, 32'h55AA_55AA, 1'b0, 1'b0);

    // 5: reset pulsed while in WAIT, late response discarded
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h8000_0300;
    mid();
    check("t5_ifu_gnt", 64'(bus.ifu_gnt), 64'(1));
    tick();
    bus.ifu_req = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    rst            = 1'b1;
    bus.ifu_req    = 1'b1;
    bus.lsu_req    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    mid();
    check("t5_rst_gnts", 64'({bus.ifu_gnt, bus.lsu_gnt}), 64'(0));
    check("t5_rst_rvalid", 64'({bus.ifu_rvalid, bus.lsu_rvalid}), 64'(0));
    check("t5_rst_mem", 64'({bus.mem_req, bus.mem_we, bus.mem_addr}), 64'(0));
    tick();
    rst         = 1'b0;
    bus.ifu_req = 1'b0;
    bus.lsu_req = 1'b0;
    mid();
    check("t5_post_rvalid", 64'({bus.ifu_rvalid, bus.lsu_rvalid}), 64'(0));
    check("t5_post_mem_req", 64'(bus.mem_req), 64'(0));
    tick();
    bus.mem_rvalid = 1'b0;
    bus.ifu_req    = 1'b1;
    bus.ifu_addr   = 32'h8000_0400;
    mid();
    check("t5_next_gnt", 64'(bus.ifu_gnt), 64'(1));
    finish_txn(1'b0, 32'h8000_0400, 32'h0000_0013, 1'b0, 1'b0);

    // 6: stray responses in IDLE and in REQ
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_0001;
    mid();
    check("t6_idle_stray", 64'({bus.ifu_rvalid, bus.lsu_rvalid}), 64'(0));
    tick();
    bus.mem_rvalid = 1'b0;
    bus.ifu_req    = 1'b1;
    bus.ifu_addr   = 32'h8000_0500;
    mid();
    check("t6_ifu_gnt", 64'(bus.ifu_gnt), 64'(1));
    tick();
    bus.ifu_req    = 1'b0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_0002;
    mid();
    check("t6_req_stray", 64'(bus.ifu_rvalid), 64'(0));
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    mid();
    check("t6_wait_req", 64'(bus.mem_req), 64'(0));
    check("t6_wait_rvalid", 64'(bus.ifu_rvalid), 64'(0));
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h600D_0003;
    push_exp(1'b0, 32'h600D_0003);
    mid();
    check("t6_real_rvalid", 64'(bus.ifu_rvalid), 64'(1));
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    mid();
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
